// File: rtl/game_session_ctrl_pkg.sv
// Shared types and per-level constants for the maze game session controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_WON  = 3'd3,
    S_LOST = 3'd4
  } state_e;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_EASY = 2'd1;
  localparam logic [1:0] LVL_MED  = 2'd2;
  localparam logic [1:0] LVL_HARD = 2'd3;

  localparam logic [7:0] INIT_SCORE = 8'd50;
  localparam logic [7:0] BONUS_STEP = 8'd5;

  typedef struct packed {
    logic [4:0] plus_x;
    logic [4:0] plus_y;
    logic [4:0] minus_x;
    logic [4:0] minus_y;
    logic [7:0] time_limit;
  } level_cfg_t;

  // Tile positions and time budget for each difficulty; LVL_NONE maps to all-zero.
  function automatic level_cfg_t level_cfg(input logic [1:0] lvl);
    level_cfg_t c;
    case (lvl)
      LVL_EASY: c = '{plus_x: 5'd17, plus_y: 5'd9,  minus_x: 5'd10, minus_y: 5'd9, time_limit: 8'd90};
      LVL_MED:  c = '{plus_x: 5'd21, plus_y: 5'd4,  minus_x: 5'd10, minus_y: 5'd6, time_limit: 8'd60};
      LVL_HARD: c = '{plus_x: 5'd1,  plus_y: 5'd21, minus_x: 5'd3,  minus_y: 5'd5, time_limit: 8'd45};
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Game session signal bundle: player/timer inputs and latched round status.
interface game_session_ctrl_if;
  logic       hard, med, easy;
  logic       start, tick1Hz, moveValid, atExit;
  logic [4:0] playerX, playerY;
  logic [1:0] level;
  logic [4:0] plusX, plusY, minusX, minusY;
  logic       plusTaken, minusTaken;
  logic [7:0] score, timeLeft;
  logic       gameActive, gameWon, gameLost, mazeReset;

  modport master (
    output hard, med, easy, start, tick1Hz, moveValid, atExit, playerX, playerY,
    input  level, plusX, plusY, minusX, minusY, plusTaken, minusTaken,
    input  score, timeLeft, gameActive, gameWon, gameLost, mazeReset
  );

  modport slave (
    input  hard, med, easy, start, tick1Hz, moveValid, atExit, playerX, playerY,
    output level, plusX, plusY, minusX, minusY, plusTaken, minusTaken,
    output score, timeLeft, gameActive, gameWon, gameLost, mazeReset
  );
endinterface

// File: rtl/game_session_ctrl_score_unit.sv
// Saturating 8-bit score adder/subtractor (clamps to 0 and 255).
module score_unit (
  input  logic [7:0] value,
  input  logic [7:0] delta,
  input  logic       sub,
  output logic [7:0] result
);
  logic [8:0] sum_s;
  logic [8:0] diff_s;

  assign sum_s  = {1'b0, value} + {1'b0, delta};
  assign diff_s = {1'b0, value} - {1'b0, delta};

  // A borrow out of the 9-bit difference means the result went below zero
  always_comb begin
    result = 8'd0;
    if (sub) begin
      if (diff_s[8]) result = 8'd0;
      else           result = diff_s[7:0];
    end else begin
      if (sum_s[8])  result = 8'hFF;
      else           result = sum_s[7:0];
    end
  end
endmodule

// File: rtl/game_session_ctrl.sv
// Maze game round controller: level latch, bonus/penalty tiles, countdown, win/lose.
// Optional: define SCORE_TIME_BONUS_EN to add remaining seconds to the score on a win.
module game_session_ctrl
  import game_pkg::*;
(
  input logic                clock,
  input logic                reset,
  game_session_ctrl_if.slave gs
);
  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_LOAD = S_LOAD;
  localparam logic [2:0] ST_PLAY = S_PLAY;
  localparam logic [2:0] ST_WON  = S_WON;
  localparam logic [2:0] ST_LOST = S_LOST;

  logic [2:0] state_r, state_nxt_s;
  logic [1:0] sel_level_s, level_r;
  logic       valid_sel_s, all_low_s;
  level_cfg_t cfg_s;
  logic [4:0] plus_x_r, plus_y_r, minus_x_r, minus_y_r;
  logic       plus_taken_r, minus_taken_r;
  logic [7:0] score_r, time_left_r;
  logic       active_r, won_r, lost_r, maze_reset_r;
  logic       plus_hit_s, minus_hit_s;
  logic [7:0] tile_score_s, tile_next_s, win_score_s;

  // Decode the difficulty switches; anything other than exactly one high is invalid
  always_comb begin
    sel_level_s = LVL_NONE;
    case ({gs.hard, gs.med, gs.easy})
      3'b001:  sel_level_s = LVL_EASY;
      3'b010:  sel_level_s = LVL_MED;
      3'b100:  sel_level_s = LVL_HARD;
      default: sel_level_s = LVL_NONE;
    endcase
  end

  assign valid_sel_s = (sel_level_s != LVL_NONE);
  assign all_low_s   = ~(gs.hard | gs.med | gs.easy);
  assign cfg_s       = level_cfg(sel_level_s);

  assign plus_hit_s  = gs.moveValid && !plus_taken_r &&
                       (gs.playerX == plus_x_r) && (gs.playerY == plus_y_r);
  assign minus_hit_s = gs.moveValid && !minus_taken_r &&
                       (gs.playerX == minus_x_r) && (gs.playerY == minus_y_r);

  score_unit u_tile (
    .value  (score_r),
    .delta  (BONUS_STEP),
    .sub    (minus_hit_s),
    .result (tile_score_s)
  );

  assign tile_next_s = (plus_hit_s || minus_hit_s) ? tile_score_s : score_r;

`ifdef SCORE_TIME_BONUS_EN
  // Win bonus stacks on top of any tile pickup made on the same move
  score_unit u_bonus (
    .value  (tile_next_s),
    .delta  (time_left_r),
    .sub    (1'b0),
    .result (win_score_s)
  );
`else
  assign win_score_s = tile_next_s;
`endif

  // Round sequencing; an all-low abort beats exit, and exit beats the final tick
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gs.start && valid_sel_s) state_nxt_s = ST_LOAD;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_PLAY;
      ST_PLAY: begin
        if (all_low_s)                                  state_nxt_s = ST_IDLE;
        else if (gs.atExit)                             state_nxt_s = ST_WON;
        else if (gs.tick1Hz && (time_left_r == 8'd1))  state_nxt_s = ST_LOST;
        else                                            state_nxt_s = ST_PLAY;
      end
      ST_WON, ST_LOST: begin
        if (gs.start && valid_sel_s) state_nxt_s = ST_LOAD;
        else if (all_low_s)          state_nxt_s = ST_IDLE;
        else                         state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, status flags and round datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      level_r       <= LVL_NONE;
      plus_x_r      <= 5'd0;
      plus_y_r      <= 5'd0;
      minus_x_r     <= 5'd0;
      minus_y_r     <= 5'd0;
      plus_taken_r  <= 1'b0;
      minus_taken_r <= 1'b0;
      score_r       <= 8'd0;
      time_left_r   <= 8'd0;
      active_r      <= 1'b0;
      won_r         <= 1'b0;
      lost_r        <= 1'b0;
      maze_reset_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      active_r     <= (state_nxt_s == ST_PLAY);
      won_r        <= (state_nxt_s == ST_WON);
      lost_r       <= (state_nxt_s == ST_LOST);
      maze_reset_r <= (state_nxt_s == ST_LOAD);
      if (state_nxt_s == ST_LOAD) begin
        level_r       <= sel_level_s;
        plus_x_r      <= cfg_s.plus_x;
        plus_y_r      <= cfg_s.plus_y;
        minus_x_r     <= cfg_s.minus_x;
        minus_y_r     <= cfg_s.minus_y;
        time_left_r   <= cfg_s.time_limit;
        score_r       <= INIT_SCORE;
        plus_taken_r  <= 1'b0;
        minus_taken_r <= 1'b0;
      end else if (state_nxt_s == ST_IDLE) begin
        level_r       <= LVL_NONE;
        plus_x_r      <= 5'd0;
        plus_y_r      <= 5'd0;
        minus_x_r     <= 5'd0;
        minus_y_r     <= 5'd0;
        time_left_r   <= 8'd0;
        score_r       <= 8'd0;
        plus_taken_r  <= 1'b0;
        minus_taken_r <= 1'b0;
      end else if (state_r == ST_PLAY) begin
        if (plus_hit_s)  plus_taken_r  <= 1'b1;
        if (minus_hit_s) minus_taken_r <= 1'b1;
        if (gs.atExit) begin
          score_r <= win_score_s;
        end else begin
          score_r <= tile_next_s;
          if (gs.tick1Hz) time_left_r <= time_left_r - 8'd1;
        end
      end
    end
  end

  assign gs.level      = level_r;
  assign gs.plusX      = plus_x_r;
  assign gs.plusY      = plus_y_r;
  assign gs.minusX     = minus_x_r;
  assign gs.minusY     = minus_y_r;
  assign gs.plusTaken  = plus_taken_r;
  assign gs.minusTaken = minus_taken_r;
  assign gs.score      = score_r;
  assign gs.timeLeft   = time_left_r;
  assign gs.gameActive = active_r;
  assign gs.gameWon    = won_r;
  assign gs.gameLost   = lost_r;
  assign gs.mazeReset  = maze_reset_r;
endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: vector table, directed corners, random vs model.
module tb_game_session_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_session_ctrl_if gif();
  game_session_ctrl dut (.clock(clk), .reset(rst), .gs(gif));

  logic [7:0] su_v, su_d, su_r;
  logic       su_s;
  score_unit u_su (.value(su_v), .delta(su_d), .sub(su_s), .result(su_r));

`ifdef SCORE_TIME_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_WON = 3, M_LOST = 4;
  int PX[4] = '{0, 17, 21, 1};
  int PY[4] = '{0, 9, 4, 21};
  int MX[4] = '{0, 10, 10, 3};
  int MY[4] = '{0, 9, 6, 5};
  int TL[4] = '{0, 90, 60, 45};

  int n_pass = 0;
  int n_checks = 0;
  int m_mode = M_IDLE, m_level = 0, m_score = 0, m_time = 0;
  bit m_pt = 1'b0, m_mt = 1'b0, m_mz = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    m_mode = M_IDLE; m_level = 0; m_score = 0; m_time = 0; m_pt = 1'b0; m_mt = 1'b0;
  endtask

  task automatic model_load(input int sel);
    m_mode = M_LOAD; m_level = sel; m_score = 50; m_time = TL[sel];
    m_pt = 1'b0; m_mt = 1'b0; m_mz = 1'b1;
  endtask

  // Reference behaviour of one clock edge given the inputs currently driven
  task automatic model_step();
    int sel;
    bit low;
    case ({gif.hard, gif.med, gif.easy})
      3'b001:  sel = 1;
      3'b010:  sel = 2;
      3'b100:  sel = 3;
      default: sel = 0;
    endcase
    low = !(gif.hard || gif.med || gif.easy);
    m_mz = 1'b0;
    if (rst) model_clear();
    else case (m_mode)
      M_IDLE: if (gif.start && sel != 0) model_load(sel);
      M_LOAD: m_mode = M_PLAY;
      M_PLAY: begin
        if (low) model_clear();
        else begin
          if (gif.moveValid && !m_pt && gif.playerX == PX[m_level] && gif.playerY == PY[m_level]) begin
            m_score = (m_score + 5 > 255) ? 255 : m_score + 5;
            m_pt = 1'b1;
          end
          if (gif.moveValid && !m_mt && gif.playerX == MX[m_level] && gif.playerY == MY[m_level]) begin
            m_score = (m_score < 5) ? 0 : m_score - 5;
            m_mt = 1'b1;
          end
          if (gif.atExit) begin
            if (BONUS) m_score = (m_score + m_time > 255) ? 255 : m_score + m_time;
            m_mode = M_WON;
          end else if (gif.tick1Hz) begin
            m_time = m_time - 1;
            if (m_time == 0) m_mode = M_LOST;
          end
        end
      end
      default: begin
        if (gif.start && sel != 0) model_load(sel);
        else if (low) model_clear();
      end
    endcase
  endtask

  task automatic cmp(input string tag);
    check({tag, ".level"}, gif.level, m_level);
    check({tag, ".plusX"}, gif.plusX, PX[m_level]);
    check({tag, ".plusY"}, gif.plusY, PY[m_level]);
    check({tag, ".minusX"}, gif.minusX, MX[m_level]);
    check({tag, ".minusY"}, gif.minusY, MY[m_level]);
    check({tag, ".plusTaken"}, gif.plusTaken, m_pt);
    check({tag, ".minusTaken"}, gif.minusTaken, m_mt);
    check({tag, ".score"}, gif.score, m_score);
    check({tag, ".timeLeft"}, gif.timeLeft, m_time);
    check({tag, ".gameActive"}, gif.gameActive, m_mode == M_PLAY);
    check({tag, ".gameWon"}, gif.gameWon, m_mode == M_WON);
    check({tag, ".gameLost"}, gif.gameLost, m_mode == M_LOST);
    check({tag, ".mazeReset"}, gif.mazeReset, m_mz);
  endtask

  task automatic set_in(input logic [2:0] sw, input logic st, input logic tk, input logic mv,
                        input logic [4:0] x, input logic [4:0] y, input logic ex);
    {gif.hard, gif.med, gif.easy} = sw;
    gif.start = st; gif.tick1Hz = tk; gif.moveValid = mv;
    gif.playerX = x; gif.playerY = y; gif.atExit = ex;
  endtask

  task automatic apply(input string tag);
    model_step();
    @(posedge clk); #1;
    cmp(tag);
  endtask

  typedef struct {
    logic [2:0] sw; logic st, tk, mv, ex; logic [4:0] x, y;
    int lvl, score, tl, pt, act, won, mz;
  } vec_t;
  vec_t tbl[9];

  typedef struct { logic [7:0] v, d; logic s; int r; } su_vec_t;
  su_vec_t su_tbl[6];

  initial begin
    logic [2:0] sw;
    int k;

    tbl[0] = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 2, 50, 60, 0, 0, 0, 1};
    tbl[1] = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 2, 50, 60, 0, 1, 0, 0};
    tbl[2] = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 5'd21, 5'd4, 2, 55, 60, 1, 1, 0, 0};
    tbl[3] = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 5'd21, 5'd4, 2, 55, 60, 1, 1, 0, 0};
    tbl[4] = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 5'd6, 2, 50, 60, 1, 1, 0, 0};
    tbl[5] = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 2, 50, 59, 1, 1, 0, 0};
    tbl[6] = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 5'd6, 2, 50, 59, 1, 1, 0, 0};
    tbl[7] = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0, 2, BONUS ? 109 : 50, 59, 1, 0, 1, 0};
    tbl[8] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 0, 0, 0, 0, 0, 0, 0};

    su_tbl[0] = '{8'd3,   8'd5,  1'b1, 0};
    su_tbl[1] = '{8'd253, 8'd5,  1'b0, 255};
    su_tbl[2] = '{8'd50,  8'd5,  1'b0, 55};
    su_tbl[3] = '{8'd100, 8'd5,  1'b1, 95};
    su_tbl[4] = '{8'd200, 8'd90, 1'b0, 255};
    su_tbl[5] = '{8'd5,   8'd5,  1'b1, 0};

    // Reset state
    set_in(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    apply("reset");
    apply("reset2");
    rst = 1'b0;

    // Invalid selection ignored in IDLE
    set_in(3'b011, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("badsel");
    check("badsel.level_const", gif.level, 0);

    // Medium round vector table
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].sw, tbl[i].st, tbl[i].tk, tbl[i].mv, tbl[i].x, tbl[i].y, tbl[i].ex);
      apply($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.level_exp", i), gif.level, tbl[i].lvl);
      check($sformatf("tbl%0d.score_exp", i), gif.score, tbl[i].score);
      check($sformatf("tbl%0d.time_exp", i), gif.timeLeft, tbl[i].tl);
      check($sformatf("tbl%0d.ptaken_exp", i), gif.plusTaken, tbl[i].pt);
      check($sformatf("tbl%0d.active_exp", i), gif.gameActive, tbl[i].act);
      check($sformatf("tbl%0d.won_exp", i), gif.gameWon, tbl[i].won);
      check($sformatf("tbl%0d.maze_exp", i), gif.mazeReset, tbl[i].mz);
    end

    // Easy round load values and one-cycle mazeReset
    set_in(3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("easy_load");
    check("easy.maze", gif.mazeReset, 1);
    check("easy.level", gif.level, 1);
    check("easy.time", gif.timeLeft, 90);
    check("easy.score", gif.score, 50);
    check("easy.plusX", gif.plusX, 17);
    check("easy.plusY", gif.plusY, 9);
    set_in(3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("easy_play");
    check("easy.maze_drop", gif.mazeReset, 0);

    // Restart into hard via all-low then hard start; 45 ticks to LOST
    set_in(3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("abort");
    check("abort.active", gif.gameActive, 0);
    check("abort.level", gif.level, 0);
    set_in(3'b100, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("hard_load");
    set_in(3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("hard_play");
    for (int i = 1; i <= 45; i++) begin
      set_in(3'b100, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
      apply("hard_tick");
      if (i == 44) begin
        check("hard.t44_time", gif.timeLeft, 1);
        check("hard.t44_active", gif.gameActive, 1);
      end
    end
    check("hard.lost", gif.gameLost, 1);
    check("hard.time0", gif.timeLeft, 0);
    apply("lost_tick_ignored");
    check("lost.time_held", gif.timeLeft, 0);

    // From LOST, restart hard; exit coincident with final tick
    set_in(3'b100, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("relaunch");
    check("relaunch.maze", gif.mazeReset, 1);
    set_in(3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("relaunch_play");
    for (int i = 1; i <= 44; i++) begin
      set_in(3'b100, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
      apply("exit_tick");
    end
    set_in(3'b100, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
    apply("exit_final");
    check("exitfinal.won", gif.gameWon, 1);
    check("exitfinal.time", gif.timeLeft, 1);
    check("exitfinal.score", gif.score, BONUS ? 51 : 50);
    set_in(3'b100, 1'b0, 1'b1, 1'b1, 5'd1, 5'd21, 1'b1);
    apply("won_ignore");
    check("won.score_held", gif.score, BONUS ? 51 : 50);

    // Mid-PLAY reset clears everything on the next edge
    set_in(3'b010, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    apply("med_load");
    set_in(3'b010, 1'b0, 1'b0, 1'b1, 5'd21, 5'd4, 1'b0);
    apply("med_move");
    rst = 1'b1;
    set_in(3'b010, 1'b1, 1'b1, 1'b1, 5'd10, 5'd6, 1'b1);
    apply("midreset");
    rst = 1'b0;
    check("midreset.score", gif.score, 0);
    check("midreset.level", gif.level, 0);
    check("midreset.time", gif.timeLeft, 0);
    check("midreset.active", gif.gameActive, 0);

    // Saturating arithmetic unit corners
    for (int i = 0; i < 6; i++) begin
      su_v = su_tbl[i].v; su_d = su_tbl[i].d; su_s = su_tbl[i].s;
      #1;
      check($sformatf("score_unit%0d", i), su_r, su_tbl[i].r);
    end

    // Randomized traffic against the reference model
    sw = 3'b001;
    for (int c = 0; c < 3000; c++) begin
      k = $urandom_range(0, 99);
      if (k < 2) sw = 3'b000;
      else if (k < 6) sw = 3'b001 << $urandom_range(0, 2);
      else if (k < 7) sw = 3'($urandom_range(0, 7));
      gif.hard = sw[2]; gif.med = sw[1]; gif.easy = sw[0];
      gif.start = ($urandom_range(0, 29) == 0);
      gif.tick1Hz = ($urandom_range(0, 3) == 0);
      gif.moveValid = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 3);
      if (k == 0) begin gif.playerX = 5'(PX[m_level]); gif.playerY = 5'(PY[m_level]); end
      else if (k == 1) begin gif.playerX = 5'(MX[m_level]); gif.playerY = 5'(MY[m_level]); end
      else begin gif.playerX = 5'($urandom_range(0, 31)); gif.playerY = 5'($urandom_range(0, 31)); end
      gif.atExit = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 499) == 0);
      apply("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
